coin_acceptor: RTL and testbench

Front end of the vending datapath: counts inserted coins into a credit register and resolves purchase and cancel requests against a price. Hands the resulting change to the coin dispenser over its `disp`/`change`/`busy`/`done` interface, then waits for the dispenser to finish. Sits between the coin-sensor inputs and the coin dispenser; the dispenser's `dispQuarter`/`dispDime`/`dispNickel` outputs do not pass through this block.

---
 rtl/coin_acceptor_if.sv | 15 +
 rtl/coin_acceptor.sv | 154 +++++++++++++++
 tb/tb_coin_acceptor.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/coin_acceptor_if.sv
// coin_acceptor_if: handshake between the coin acceptor and the coin dispenser.
//   disp     : acceptor -> dispenser, 1-cycle dispense request
//   change   : acceptor -> dispenser, amount to pay out (cents), held after disp
//   dispBusy : dispenser -> acceptor, dispenser busy level (status only)
//   dispDone : dispenser -> acceptor, 1-cycle completion pulse
// master = coin acceptor side, slave = dispenser side.
interface coin_acceptor_if;
    logic       disp;
    logic [9:0] change;
    logic       dispBusy;
    logic       dispDone;

    modport master (output disp, output change, input dispBusy, input dispDone);
    modport slave  (input disp, input change, output dispBusy, output dispDone);
endinterface

// File: rtl/coin_acceptor.sv
// coin_acceptor: counts coin-sensor edges into a credit register and resolves
// purchase/cancel requests against a price, handing change to the dispenser.
// Ports:
//   clk, rst_n                        : clock, synchronous active-low reset
//   coinQuarter/coinDime/coinNickel   : sensor levels, each rising edge is one coin
//   vend, cancel                      : request levels, acted on at rising edge
//   price                             : item price, latched on the vend edge
//   dsp (coin_acceptor_if.master)     : disp/change out, dispBusy/dispDone in
//   credit                            : accumulated credit
//   vendOk/insufficient/coinReject    : 1-cycle status pulses
//   busy                              : high whenever the FSM is not IDLE
module coin_acceptor #(
    parameter int QUARTER_VALUE = 25,
    parameter int DIME_VALUE    = 10,
    parameter int NICKEL_VALUE  = 5,
    parameter int MAX_CREDIT    = 1000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   coinQuarter,
    input  logic                   coinDime,
    input  logic                   coinNickel,
    input  logic                   vend,
    input  logic                   cancel,
    input  logic [9:0]             price,
    coin_acceptor_if.master        dsp,
    output logic [9:0]             credit,
    output logic                   vendOk,
    output logic                   insufficient,
    output logic                   coinReject,
    output logic                   busy
);

    typedef enum logic [1:0] {IDLE, CHECK, REQ, WAIT_DONE} state_t;

    state_t     state;
    logic       prev_q, prev_d, prev_n, prev_v, prev_c;
    logic [9:0] price_q;
    logic [9:0] change_r;
    logic       disp_r;

    logic       q_rise, d_rise, n_rise, v_rise, c_rise, any_coin;
    logic [10:0] coin_sum, credit_sum;
    logic       coin_fits;
    logic [9:0] credit_new;

    assign q_rise   = coinQuarter & ~prev_q;
    assign d_rise   = coinDime    & ~prev_d;
    assign n_rise   = coinNickel  & ~prev_n;
    assign v_rise   = vend        & ~prev_v;
    assign c_rise   = cancel      & ~prev_c;
    assign any_coin = q_rise | d_rise | n_rise;

    // Simultaneous coin edges are summed and accepted or refused as one group.
    always_comb begin
        coin_sum   = (q_rise ? 11'(QUARTER_VALUE) : 11'd0)
                   + (d_rise ? 11'(DIME_VALUE)    : 11'd0)
                   + (n_rise ? 11'(NICKEL_VALUE)  : 11'd0);
        credit_sum = {1'b0, credit} + coin_sum;
        coin_fits  = (credit_sum <= 11'(MAX_CREDIT));
        // credit_sum never exceeds MAX_CREDIT (<= 1023) when it fits
        credit_new = coin_fits ? credit_sum[9:0] : credit;
    end

    assign dsp.disp   = disp_r;
    assign dsp.change = change_r;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            prev_q       <= 1'b0;
            prev_d       <= 1'b0;
            prev_n       <= 1'b0;
            prev_v       <= 1'b0;
            prev_c       <= 1'b0;
            price_q      <= '0;
            change_r     <= '0;
            disp_r       <= 1'b0;
            credit       <= '0;
            vendOk       <= 1'b0;
            insufficient <= 1'b0;
            coinReject   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            // edge trackers follow the inputs in every state
            prev_q       <= coinQuarter;
            prev_d       <= coinDime;
            prev_n       <= coinNickel;
            prev_v       <= vend;
            prev_c       <= cancel;
            vendOk       <= 1'b0;
            insufficient <= 1'b0;
            coinReject   <= 1'b0;
            disp_r       <= 1'b0;

            case (state)
                IDLE: begin
                    if (any_coin && !coin_fits)
                        coinReject <= 1'b1;
                    // cancel wins over vend; same-cycle coins join the refund
                    if (c_rise && credit_new != 10'd0) begin
                        change_r <= credit_new;
                        credit   <= '0;
                        state    <= REQ;
                        busy     <= 1'b1;
                    end else begin
                        credit <= credit_new;
                        if (v_rise && !c_rise) begin
                            price_q <= price;
                            state   <= CHECK;
                            busy    <= 1'b1;
                        end
                    end
                end
                CHECK: begin
                    coinReject <= any_coin;
                    if (credit >= price_q) begin
                        vendOk   <= 1'b1;
                        change_r <= credit - price_q;
                        credit   <= '0;
                        if (credit != price_q) begin
                            state <= REQ;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        insufficient <= 1'b1;
                        state        <= IDLE;
                        busy         <= 1'b0;
                    end
                end
                REQ: begin
                    // disp was low last cycle, so the dispenser sees a clean rise
                    coinReject <= any_coin;
                    disp_r     <= 1'b1;
                    state      <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    coinReject <= any_coin;
                    if (dsp.dispDone) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coin_acceptor.sv
// tb_coin_acceptor: scoreboard bench for coin_acceptor. Stimulus tasks compute
// the expected pulses (kind, value, cycle) from the credit rules and queue them;
// a monitor process pops and compares whenever the DUT raises a pulse output.
module tb_coin_acceptor;

    localparam int MAXC  = 1000;
    localparam int K_REJ = 0;
    localparam int K_OK  = 1;
    localparam int K_INS = 2;
    localparam int K_DSP = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       coinQuarter, coinDime, coinNickel, vend, cancel;
    logic [9:0] price;
    logic [9:0] credit;
    logic       vendOk, insufficient, coinReject, busy;

    coin_acceptor_if dif();

    coin_acceptor dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .coinQuarter  (coinQuarter),
        .coinDime     (coinDime),
        .coinNickel   (coinNickel),
        .vend         (vend),
        .cancel       (cancel),
        .price        (price),
        .dsp          (dif),
        .credit       (credit),
        .vendOk       (vendOk),
        .insufficient (insufficient),
        .coinReject   (coinReject),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int val;
        int cyc;
    } ev_t;

    ev_t expq[$];
    int  errors = 0;
    int  checks = 0;
    int  mcredit = 0;   // reference credit

    function automatic string kname(int k);
        case (k)
            K_REJ:   return "coinReject";
            K_OK:    return "vendOk";
            K_INS:   return "insufficient";
            default: return "disp";
        endcase
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(int kind, int val, int c);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.cyc  = c;
        expq.push_back(e);
    endtask

    task automatic obs(int kind, int val);
        ev_t e;
        if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_%s: got value %0d at cycle %0d, expected no pulse",
                     kname(kind), val, cyc);
        end else begin
            e = expq.pop_front();
            chk({"ev_kind_", kname(kind)}, kind, e.kind);
            chk({"ev_val_", kname(kind)}, val, e.val);
            chk({"ev_cycle_", kname(kind)}, cyc, e.cyc);
        end
    endtask

    // monitor: compares every pulse the DUT presents against the queue
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (coinReject)   obs(K_REJ, int'(credit));
                if (vendOk)       obs(K_OK,  int'(dif.change));
                if (insufficient) obs(K_INS, int'(credit));
                if (dif.disp)     obs(K_DSP, int'(dif.change));
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic coin(bit q, bit d, bit n);
        int k, sum;
        @(negedge clk);
        k   = cyc + 1;
        sum = (q ? 25 : 0) + (d ? 10 : 0) + (n ? 5 : 0);
        if (mcredit + sum <= MAXC) mcredit += sum;
        else push(K_REJ, mcredit, k);
        coinQuarter = q; coinDime = d; coinNickel = n;
        @(negedge clk);
        coinQuarter = 0; coinDime = 0; coinNickel = 0;
    endtask

    task automatic check_zero_outputs(string tag);
        chk({tag, "_credit"}, credit, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_change"}, dif.change, 0);
        chk({tag, "_disp"}, dif.disp, 0);
        chk({tag, "_pulses"}, {vendOk, insufficient, coinReject}, 0);
    endtask

    // waits for disp, checks it, optionally injects a coin during WAIT_DONE,
    // then completes with dispDone or a reset
    task automatic finish_disp(int chg, bit inject, bit do_reset);
        int n = 0;
        while (dif.disp !== 1'b1 && n < 12) begin
            @(negedge clk);
            n++;
        end
        chk("disp_seen", dif.disp, 1);
        chk("busy_req", busy, 1);
        @(negedge clk);
        chk("disp_width", dif.disp, 0);
        chk("change_hold", dif.change, chg);
        if (inject) begin
            coinQuarter = 1;
            push(K_REJ, mcredit, cyc + 1);
            @(negedge clk);
            coinQuarter = 0;
            chk("credit_wait", credit, mcredit);
            chk("busy_wait", busy, 1);
        end
        repeat ($urandom_range(0, 3)) @(negedge clk);
        if (do_reset) begin
            rst_n = 0;
            @(negedge clk);
            rst_n   = 1;
            mcredit = 0;
            check_zero_outputs("midreset");
        end else begin
            dif.dispDone = 1;
            @(negedge clk);
            dif.dispDone = 0;
            chk("busy_done", busy, 0);
        end
    endtask

    task automatic vend_tx(int p, bit inject);
        int  k, chg;
        bit  ok;
        @(negedge clk);
        k     = cyc + 1;
        vend  = 1;
        price = 10'(p);
        ok    = (mcredit >= p);
        chg   = 0;
        if (ok) begin
            chg = mcredit - p;
            push(K_OK, chg, k + 1);
            mcredit = 0;
            if (chg != 0) push(K_DSP, chg, k + 2);
        end else begin
            push(K_INS, mcredit, k + 1);
        end
        @(negedge clk);
        vend  = 0;
        price = 10'($urandom_range(0, 1023));   // latched copy must be used
        chk("busy_check", busy, 1);
        if (ok && chg != 0) begin
            finish_disp(chg, inject, 0);
        end else begin
            @(negedge clk);
            chk("busy_idle_after_check", busy, 0);
        end
    endtask

    task automatic cancel_tx(bit inject);
        int chg = 0;
        @(negedge clk);
        cancel = 1;
        if (mcredit > 0) begin
            chg = mcredit;
            push(K_DSP, chg, cyc + 2);
            mcredit = 0;
        end
        @(negedge clk);
        cancel = 0;
        if (chg > 0) finish_disp(chg, inject, 0);
        else chk("busy_cancel_zero", busy, 0);
    endtask

    initial begin
        rst_n = 0;
        coinQuarter = 0; coinDime = 0; coinNickel = 0;
        vend = 0; cancel = 0; price = '0;
        dif.dispDone = 0; dif.dispBusy = 0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1;

        // Q, Q, D -> 60; buy at 50 -> change 10
        coin(1, 0, 0); coin(1, 0, 0); coin(0, 1, 0);
        chk("credit_60", credit, 60);
        vend_tx(50, 0);
        chk("credit_after_buy", credit, 0);

        // 35 vs price 50 -> insufficient, credit kept
        coin(1, 0, 0); coin(0, 1, 0);
        vend_tx(50, 0);
        chk("credit_kept_35", credit, 35);

        // 40 cancel -> refund; repeat at 0 -> nothing
        coin(0, 0, 1);
        chk("credit_40", credit, 40);
        cancel_tx(0);
        chk("credit_after_cancel", credit, 0);
        cancel_tx(0);
        chk("credit_cancel_zero", credit, 0);

        // ceiling behaviour around MAX_CREDIT
        repeat (39) coin(1, 0, 0);
        coin(0, 1, 1);
        chk("credit_990", credit, 990);
        coin(1, 0, 0);
        chk("credit_990_rej", credit, 990);
        coin(0, 0, 1);
        chk("credit_995", credit, 995);
        coin(0, 1, 1);
        chk("credit_995_rej", credit, 995);
        cancel_tx(0);

        // exact price -> vendOk, no disp
        repeat (3) coin(1, 0, 0);
        vend_tx(75, 0);
        chk("credit_exact", credit, 0);

        // coin during WAIT_DONE, then reset before dispDone
        coin(1, 0, 0);
        @(negedge clk);
        cancel = 1;
        push(K_DSP, 25, cyc + 2);
        mcredit = 0;
        @(negedge clk);
        cancel = 0;
        finish_disp(25, 1, 1);
        coin(0, 0, 1);
        chk("credit_after_reset", credit, 5);

        // randomized transactions
        for (int t = 0; t < 250; t++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 6) begin
                bit q, d, n;
                q = 1'($urandom_range(0, 1));
                d = 1'($urandom_range(0, 1));
                n = 1'($urandom_range(0, 1));
                if (!(q | d | n)) q = 1;
                coin(q, d, n);
            end else if (r < 8) begin
                vend_tx($urandom_range(0, mcredit + 60), 1'($urandom_range(0, 1)));
            end else begin
                cancel_tx(1'($urandom_range(0, 1)));
            end
            dif.dispBusy = 1'($urandom_range(0, 1));
            chk("credit_rand", credit, mcredit);
        end

        repeat (4) @(negedge clk);
        chk("queue_drained", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
